ser_bitstream_feeder: RTL and testbench

//  - Parallel-to-serial front end for the serial sequence-detector path.
//  - Accepts W-bit words on a valid/ready handshake and emits them MSB-first, one bit per clk.
//  - sout drives the detector's serial ip input directly; sout_vld marks real data bits.

---
 rtl/ser_pkg.sv | 15 +
 rtl/ser_hold_reg.sv | 27 ++
 rtl/ser_bitstream_feeder.sv | 132 +++++++++++++
 tb/tb_ser_bitstream_feeder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types, defaults and helpers for the serial bitstream feeder
package ser_pkg;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_W_DEFAULT = 8;

    function automatic int ser_cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// rtl/ser_hold_reg.sv - one-word holding register with full flag for the prefetch path
module ser_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    input  logic         load,
    input  logic         unload,
    output logic [W-1:0] q,
    output logic         full
);

    // A load in the same cycle as an unload refills the slot, so full stays set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/ser_bitstream_feeder.sv
// rtl/ser_bitstream_feeder.sv - MSB-first parallel-to-serial feeder; SER_PREFETCH_EN adds a one-word prefetch buffer
module ser_bitstream_feeder
    import ser_pkg::*;
#(
    parameter int   W        = SER_W_DEFAULT,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_vld,
    output logic         din_rdy,
    output logic         sout,
    output logic         sout_vld,
    output logic         busy
);

    localparam int            CW       = ser_cnt_w(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    ser_state_t    state;
    ser_state_t    state_nxt;
    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last_bit;
    logic          load_word;
    logic [W-1:0]  load_data;

    assign accept   = din_vld & din_rdy;
    assign last_bit = (state == SER_SHIFT) && (cnt == CNT_LAST);

`ifdef SER_PREFETCH_EN
    logic         hold_full;
    logic         hold_load;
    logic         hold_unload;
    logic [W-1:0] hold_q;

    ser_hold_reg #(
        .W(W)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .d      (din),
        .load   (hold_load),
        .unload (hold_unload),
        .q      (hold_q),
        .full   (hold_full)
    );

    assign din_rdy = !hold_full;
    assign busy    = (state == SER_SHIFT) || hold_full;
`else
    assign din_rdy = (state == SER_IDLE);
    assign busy    = (state == SER_SHIFT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SER_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_word = 1'b0;
        load_data = din;
`ifdef SER_PREFETCH_EN
        hold_load   = 1'b0;
        hold_unload = 1'b0;
`endif
        case (state)
            SER_IDLE: begin
                if (accept) begin
                    load_word = 1'b1;
                    state_nxt = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (cnt == CNT_LAST) begin
`ifdef SER_PREFETCH_EN
                    // The held word takes priority so stream order matches accept order.
                    if (hold_full) begin
                        load_word   = 1'b1;
                        load_data   = hold_q;
                        hold_unload = 1'b1;
                        hold_load   = accept;
                    end else
`endif
                    if (accept) begin
                        load_word = 1'b1;
                    end else begin
                        state_nxt = SER_IDLE;
                    end
                end
`ifdef SER_PREFETCH_EN
                else begin
                    hold_load = accept;
                end
`endif
            end
            default: state_nxt = SER_IDLE;
        endcase
    end

    // shreg holds the not-yet-emitted bits left-aligned; the MSB goes straight to sout on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            cnt      <= '0;
            sout     <= IDLE_BIT;
            sout_vld <= 1'b0;
        end else if (load_word) begin
            sout     <= load_data[W-1];
            shreg    <= {load_data[W-2:0], 1'b0};
            cnt      <= '0;
            sout_vld <= 1'b1;
        end else if ((state == SER_SHIFT) && !last_bit) begin
            sout     <= shreg[W-1];
            shreg    <= {shreg[W-2:0], 1'b0};
            cnt      <= cnt + 1'b1;
            sout_vld <= 1'b1;
        end else begin
            cnt      <= '0;
            sout     <= IDLE_BIT;
            sout_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ser_bitstream_feeder.sv
// tb/tb_ser_bitstream_feeder.sv - directed self-checking bench for ser_bitstream_feeder
module tb_ser_bitstream_feeder;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_vld;
    logic       din_rdy;
    logic       sout;
    logic       sout_vld;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_bits;
    } vec_t;

    vec_t vecs[7];

    ser_bitstream_feeder #(
        .W        (8),
        .IDLE_BIT (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .sout     (sout),
        .sout_vld (sout_vld),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_single(input logic [7:0] w, output logic [7:0] got, output int nvld);
        @(negedge clk);
        din     = w;
        din_vld = 1'b1;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        got  = '0;
        nvld = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (sout_vld) nvld++;
            got = {got[6:0], sout};
        end
    endtask

    task automatic run_stream(input logic [7:0] words[4], input int n,
                              output logic [7:0] got[4], output int nbits,
                              output int gaps, output logic rdy_low);
        int         idx;
        logic       fire;
        logic       started;
        logic [7:0] acc;
        idx     = 0;
        fire    = 1'b0;
        started = 1'b0;
        acc     = '0;
        nbits   = 0;
        gaps    = 0;
        rdy_low = 1'b0;
        for (int i = 0; i < 4; i++) got[i] = '0;
        for (int cyc = 0; cyc < 200 && nbits < n * 8; cyc++) begin
            @(negedge clk);
            if (fire) idx++;
            if (sout_vld) begin
                started = 1'b1;
                acc     = {acc[6:0], sout};
                nbits++;
                if (nbits % 8 == 0) got[nbits / 8 - 1] = acc;
            end else if (started) begin
                gaps++;
            end
            if (!din_rdy) rdy_low = 1'b1;
            if (idx < n) begin
                din     = words[idx];
                din_vld = 1'b1;
            end else begin
                din_vld = 1'b0;
            end
            #1;
            fire = din_vld & din_rdy;
        end
        din_vld = 1'b0;
    endtask

    initial begin
        logic [7:0] got;
        int         nvld;
        logic [7:0] sw[4];
        logic [7:0] sg[4];
        int         nbits;
        int         gaps;
        logic       rdy_low;
        int         exp_gaps;
        int         seen;

        vecs[0] = '{8'hA6, 8'b1010_0110};
        vecs[1] = '{8'h53, 8'b0101_0011};
        vecs[2] = '{8'hF0, 8'b1111_0000};
        vecs[3] = '{8'h01, 8'b0000_0001};
        vecs[4] = '{8'h80, 8'b1000_0000};
        vecs[5] = '{8'hFF, 8'b1111_1111};
        vecs[6] = '{8'h00, 8'b0000_0000};

`ifdef SER_PREFETCH_EN
        exp_gaps = 0;
`else
        exp_gaps = 1;
`endif

        // Reset held with din_vld high
        rst     = 1'b1;
        din     = 8'hFF;
        din_vld = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sout", {31'b0, sout}, 32'd0);
        check("rst_sout_vld", {31'b0, sout_vld}, 32'd0);
        check("rst_din_rdy", {31'b0, din_rdy}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        din_vld = 1'b0;
        rst     = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_no_accept_vld", {31'b0, sout_vld}, 32'd0);
        check("post_rst_no_accept_busy", {31'b0, busy}, 32'd0);

        // Single-word table
        for (int v = 0; v < 7; v++) begin
            send_single(vecs[v].word, got, nvld);
            check($sformatf("single_bits_%02h", vecs[v].word), {24'b0, got}, {24'b0, vecs[v].exp_bits});
            check($sformatf("single_nvld_%02h", vecs[v].word), nvld, 32'd8);
            if (v == 0) check("a6_first7", {25'b0, got[7:1]}, {25'b0, 7'b1010011});
            @(negedge clk);
            check($sformatf("single_end_vld_%02h", vecs[v].word), {31'b0, sout_vld}, 32'd0);
            check($sformatf("single_end_sout_%02h", vecs[v].word), {31'b0, sout}, 32'd0);
            check($sformatf("single_end_busy_%02h", vecs[v].word), {31'b0, busy}, 32'd0);
        end

        // Back-to-back A6, 53
        sw[0] = 8'hA6; sw[1] = 8'h53; sw[2] = 8'h00; sw[3] = 8'h00;
        run_stream(sw, 2, sg, nbits, gaps, rdy_low);
        check("b2b_nbits", nbits, 32'd16);
        check("b2b_word0", {24'b0, sg[0]}, 32'hA6);
        check("b2b_word1", {24'b0, sg[1]}, 32'h53);
        check("b2b_gaps", gaps, exp_gaps);
        check("b2b_rdy_dropped", {31'b0, rdy_low}, 32'd1);
        repeat (3) @(negedge clk);
        check("b2b_end_vld", {31'b0, sout_vld}, 32'd0);

        // Third word waits on din_rdy=0 while hold is full; must appear exactly once
        sw[0] = 8'hA6; sw[1] = 8'h53; sw[2] = 8'h3C;
        run_stream(sw, 3, sg, nbits, gaps, rdy_low);
        check("stall_nbits", nbits, 32'd24);
        check("stall_word0", {24'b0, sg[0]}, 32'hA6);
        check("stall_word1", {24'b0, sg[1]}, 32'h53);
        check("stall_word2", {24'b0, sg[2]}, 32'h3C);
        check("stall_gaps", gaps, 2 * exp_gaps);
        repeat (3) @(negedge clk);
        check("stall_end_vld", {31'b0, sout_vld}, 32'd0);
        check("stall_end_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset after the 3rd bit, with a second word offered
        @(negedge clk);
        din     = 8'hA6;
        din_vld = 1'b1;
        @(posedge clk);
        #1;
        din = 8'h53;
        repeat (3) @(negedge clk);
        din_vld = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_sout", {31'b0, sout}, 32'd0);
        check("async_rst_sout_vld", {31'b0, sout_vld}, 32'd0);
        check("async_rst_din_rdy", {31'b0, din_rdy}, 32'd1);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (sout_vld) seen++;
        end
        check("async_rst_discard", seen, 32'd0);
        send_single(8'hF0, got, nvld);
        check("after_rst_f0_bits", {24'b0, got}, 32'hF0);
        check("after_rst_f0_nvld", nvld, 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
